// File: rtl/discus_snoop_pkg.sv
// discus_snoop_pkg: snoop-port constants and FSM states shared by the dump reader and program loader
package discus_snoop_pkg;
    localparam int SNOOP_ADDR_W = 8;
    localparam int SNOOP_DATA_W = 8;
    localparam logic SNOOPM_READ = 1'b1;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } snoop_state_e;
endpackage

// File: rtl/snoop_dump.sv
// snoop_dump: walks discus program memory over the snoop port and streams (address, data) pairs
module snoop_dump
    import discus_snoop_pkg::*;
#(
    parameter int ADDR_W    = SNOOP_ADDR_W,
    parameter int DATA_W    = SNOOP_DATA_W,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              snoopp,
    output logic              snoopm,
    output logic [ADDR_W-1:0] snoopa,
    output logic [DATA_W-1:0] snoopd,
    input  logic [DATA_W-1:0] snoopq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);
    snoop_state_e state, nxt;
    logic [ADDR_W-1:0] cnt;
    logic last, adv;
    assign last = &cnt;
    assign busy = state == ISSUE || state == CAPTURE || state == EMIT;
    assign snoopp = busy;
    assign snoopm = snoopp ? SNOOPM_READ : 1'b0;
    assign snoopa = cnt;
    assign snoopd = '0;
    assign out_valid = state == EMIT;
    assign done = state == DONE;
    // advance fires on a skipped zero byte in CAPTURE or on the EMIT handshake
    always_comb begin
        adv = 1'b0;
        nxt = state;
        case (state)
            IDLE: nxt = start ? ISSUE : IDLE;
            ISSUE: nxt = CAPTURE;
            CAPTURE: begin
                adv = SKIP_ZERO && snoopq == '0;
                nxt = adv ? (last ? DONE : ISSUE) : EMIT;
            end
            EMIT: begin
                adv = out_ready;
                nxt = out_ready ? (last ? DONE : ISSUE) : EMIT;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start)
                cnt <= '0;
            else if (adv && !last)
                cnt <= cnt + 1'b1;
            if (state == CAPTURE) begin
                out_addr <= cnt;
                out_data <= snoopq;
            end
        end
    end
endmodule

// File: tb/tb_snoop_dump.sv
// tb_snoop_dump: randomized checks of two snoop_dump instances (SKIP_ZERO=0 and 1) against a memory-walk model
module tb_snoop_dump;
    logic clk = 1'b0, reset = 1'b0;
    logic [1:0] start = '0, out_ready = '1;
    logic [1:0] busy, done, snoopp, snoopm, out_valid;
    logic [7:0] snoopa [2], snoopd [2], snoopq [2], out_addr [2], out_data [2];
    logic [7:0] mem [2][256];
    logic [15:0] got [2][$];
    int done_cnt [2] = '{0, 0}, done_edge [2] = '{0, 0}, en_err [2] = '{0, 0}, hold_err [2] = '{0, 0};
    int gb [2], db [2], eb [2], hb [2], e0 [2];
    logic [1:0] pv = '0, pr = '0;
    logic prst = 1'b0;
    logic [7:0] pa [2], pd [2];
    int edges = 0, total = 0, bad = 0;
    logic [7:0] pre [10] = '{8'h03, 8'h00, 8'ha8, 8'h06, 8'h00, 8'ha8, 8'h09, 8'h00, 8'ha8, 8'ha8};

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    snoop_dump #(.SKIP_ZERO(1'b0)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .snoopp(snoopp[0]), .snoopm(snoopm[0]), .snoopa(snoopa[0]), .snoopd(snoopd[0]),
        .snoopq(snoopq[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_addr(out_addr[0]), .out_data(out_data[0])
    );
    snoop_dump #(.SKIP_ZERO(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .snoopp(snoopp[1]), .snoopm(snoopm[1]), .snoopa(snoopa[1]), .snoopd(snoopd[1]),
        .snoopq(snoopq[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_addr(out_addr[1]), .out_data(out_data[1])
    );

    // synchronous read memory: data for an address appears one cycle later
    always @(posedge clk)
        for (int i = 0; i < 2; i++) snoopq[i] <= mem[i][snoopa[i]];

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            if (out_valid[i] && out_ready[i]) got[i].push_back({out_addr[i], out_data[i]});
            if (done[i]) begin
                done_edge[i] = edges;
                done_cnt[i]++;
            end
            if (busy[i] !== snoopp[i] || snoopm[i] !== snoopp[i] || snoopd[i] !== 8'h00 || (out_valid[i] && !snoopp[i]))
                en_err[i]++;
            if (prst && pv[i] && !pr[i] && {out_valid[i], out_addr[i], out_data[i]} !== {1'b1, pa[i], pd[i]})
                hold_err[i]++;
            pv[i] = out_valid[i];
            pr[i] = out_ready[i];
            pa[i] = out_addr[i];
            pd[i] = out_data[i];
            if (i == 1) prst = reset;
        end

    task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input int i);
        gb[i] = got[i].size();
        db[i] = done_cnt[i];
        eb[i] = en_err[i];
        hb[i] = hold_err[i];
    endtask

    task automatic kick(input int i);
        start[i] = 1'b1;
        e0[i] = edges + 1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input bit rnd);
        int n = 0;
        while (done_cnt[i] == db[i] && n < 4000) begin
            if (rnd) out_ready[i] = $urandom_range(0, 3) != 0;
            tick();
            n++;
        end
        out_ready[i] = 1'b1;
        chk("done_timeout", n < 4000, 1);
        repeat (4) tick();
    endtask

    // reference: every address 0..255 in order, zero bytes dropped when skipping; 3 cycles per beat, 2 per skip
    task automatic verify(input int i, input string tag, input bit timed);
        logic [15:0] want [$];
        int cyc = 0;
        bit skipz = i == 1;
        for (int a = 0; a < 256; a++)
            if (!skipz || mem[i][a] != 8'h00) begin
                want.push_back({a[7:0], mem[i][a]});
                cyc += 3;
            end else cyc += 2;
        chk({tag, ".len"}, got[i].size() - gb[i], want.size());
        for (int k = 0; k < want.size() && gb[i] + k < got[i].size(); k++)
            chk({tag, ".beat"}, got[i][gb[i] + k], want[k]);
        if (timed) chk({tag, ".lat"}, done_edge[i] - e0[i], cyc);
        chk({tag, ".done"}, done_cnt[i] - db[i], 1);
        chk({tag, ".bus"}, en_err[i] - eb[i] + hold_err[i] - hb[i], 0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst.ctl", {busy, done, snoopp, snoopm, out_valid}, 0);
        for (int i = 0; i < 2; i++)
            chk("rst.dat", {snoopa[i], snoopd[i], out_addr[i], out_data[i]}, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++) mem[i][a] = a < 10 ? pre[a] : 8'h00;

        prep(1); kick(1); wait_done(1, 0); verify(1, "tp_skip", 1);
        prep(0); kick(0); wait_done(0, 0); verify(0, "tp_all", 1);
        chk("tp_all.b1", got[0].size() > gb[0] + 1 ? got[0][gb[0] + 1] : 16'hxxxx, 16'h0100);
        chk("tp_all.last", got[0].size() > 0 ? got[0][got[0].size() - 1] : 16'hxxxx, 16'hff00);

        prep(1); kick(1);
        n = 0;
        while (!(snoopp[1] && snoopa[1] == 8'h02) && n < 100) begin tick(); n++; end
        out_ready[1] = 1'b0;
        while (!out_valid[1] && n < 100) begin tick(); n++; end
        chk("bp.reach", n < 100, 1);
        repeat (5) begin
            chk("bp.hold", {out_valid[1], out_addr[1], out_data[1], snoopa[1]}, {1'b1, 8'h02, 8'ha8, 8'h02});
            tick();
        end
        out_ready[1] = 1'b1;
        wait_done(1, 0); verify(1, "bp", 0);

        prep(1); kick(1);
        n = 0;
        while (!(snoopp[1] && snoopa[1] == 8'h05) && n < 100) begin tick(); n++; end
        chk("busy.reach", n < 100, 1);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        wait_done(1, 0); verify(1, "busy_start", 1);

        kick(1);
        n = 0;
        while (!out_valid[1] && n < 100) begin tick(); n++; end
        chk("mid.reach", n < 100, 1);
        reset = 1'b0;
        tick();
        chk("mid.rst", {snoopp[1], out_valid[1], busy[1]}, 0);
        reset = 1'b1;
        tick();
        prep(1); kick(1); wait_done(1, 0); verify(1, "restart", 1);

        for (int a = 0; a < 256; a++) mem[1][a] = 8'h00;
        prep(1); kick(1); wait_done(1, 0); verify(1, "zero", 1);

        repeat (3)
            for (int i = 0; i < 2; i++) begin
                for (int a = 0; a < 256; a++) mem[i][a] = $urandom_range(0, 2) == 0 ? 8'h00 : 8'($urandom);
                prep(i); kick(i); wait_done(i, 1); verify(i, "rand", 0);
            end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
